// File: rtl/adder_test_pkg.sv
// Shared definitions for the adder probe family (half, full and ripple adders).
// Provides the probe FSM state encoding and the width derivations for the
// error counter and the failing-vector index.
package adder_test_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // The error count must hold 4^W, the number of vectors in a run.
  function automatic int unsigned err_count_w(input int unsigned width);
    return 2 * width + 1;
  endfunction

  // One index per {a,b} operand pair.
  function automatic int unsigned fail_vec_w(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/adder_golden.sv
// Golden reference adder for the probe checker.
// Ports:
//   a, b : WIDTH-bit operands
//   sum  : WIDTH+1-bit zero-extended a+b
module adder_golden #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/adder_probe_seq.sv
// Exhaustive sequential probe for a combinational adder.
// On start it walks every {a,b} pair in increasing order, holds each pair
// for SETTLE_CYCLES cycles, then compares {c,s} against a golden a+b.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : run request, honoured only in IDLE and DONE
//   a, b       : operands driven to the adder under test
//   s, c       : sum and carry returned by the adder under test
//   busy, done : run in progress / run finished (level)
//   pass       : no mismatches in the last run (valid while done)
//   err_count  : saturating count of mismatching vectors
//   fail_vec   : index of the first mismatching vector
module adder_probe_seq
  import adder_test_pkg::*;
#(
  parameter int unsigned WIDTH         = 1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic [WIDTH-1:0]                 a,
  output logic [WIDTH-1:0]                 b,
  input  logic [WIDTH-1:0]                 s,
  input  logic                             c,
  output logic                             busy,
  output logic                             done,
  output logic                             pass,
  output logic [err_count_w(WIDTH)-1:0]    err_count,
  output logic [fail_vec_w(WIDTH)-1:0]     fail_vec
);

  localparam int unsigned EW = err_count_w(WIDTH);
  localparam int unsigned VW = fail_vec_w(WIDTH);
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [VW-1:0] VEC_LAST   = '1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] vec_q, vec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [EW-1:0] err_q, err_d;
  logic [VW-1:0] fv_q, fv_d;

  logic [WIDTH:0] expected;
  logic           mismatch;

  assign a = vec_q[VW-1:WIDTH];
  assign b = vec_q[WIDTH-1:0];

  adder_golden #(.WIDTH(WIDTH)) u_golden (
    .a   (a),
    .b   (b),
    .sum (expected)
  );

  assign mismatch = ({c, s} != expected);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fv_d    = '0;
          cnt_d   = CNT_RELOAD;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + EW'(1);
          end
          if (err_q == '0) begin
            fv_d = vec_q;
          end
        end
        // Terminal vector detected by compare so vec never wraps mid-run.
        if (vec_q == VEC_LAST) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_q == '0) && !mismatch;
        end else begin
          vec_d   = vec_q + VW'(1);
          cnt_d   = CNT_RELOAD;
          state_d = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_adder_probe_seq.sv
// Self-checking bench for adder_probe_seq: three instances (W1/S2, W1/S1,
// W2/S1) each driving a bench-side dataflow adder with optional faults.
module tb_adder_probe_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic st1, st2, st3;
  int   fm1, fm2;  // 0 = correct, 1 = carry stuck at 0, 2 = sum inverted

  logic       a1, b1, s1, c1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] fv1, sum1;
  logic       a2, b2, s2, c2, busy2, done2, pass2;
  logic [2:0] err2;
  logic [1:0] fv2, sum2;
  logic [1:0] a3, b3, s3;
  logic       c3, busy3, done3, pass3;
  logic [4:0] err3;
  logic [3:0] fv3;
  logic [2:0] sum3;

  always_comb begin
    sum1 = {1'b0, a1} + {1'b0, b1};
    s1   = sum1[0] ^ (fm1 == 2);
    c1   = (fm1 == 1) ? 1'b0 : sum1[1];
    sum2 = {1'b0, a2} + {1'b0, b2};
    s2   = sum2[0] ^ (fm2 == 2);
    c2   = (fm2 == 1) ? 1'b0 : sum2[1];
    sum3 = {1'b0, a3} + {1'b0, b3};
    s3   = sum3[1:0];
    c3   = sum3[2];
  end

  adder_probe_seq #(.WIDTH(1), .SETTLE_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .s(s1), .c(c1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1));
  adder_probe_seq #(.WIDTH(1), .SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst(rst), .start(st2), .a(a2), .b(b2), .s(s2), .c(c2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2));
  adder_probe_seq #(.WIDTH(2), .SETTLE_CYCLES(1)) u3 (
    .clk(clk), .rst(rst), .start(st3), .a(a3), .b(b3), .s(s3), .c(c3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3));

  // Selected-instance view, zero-extended to the widest instance.
  int         sel;
  logic [3:0] m_a, m_b, m_fv;
  logic [4:0] m_err;
  logic       m_busy, m_done, m_pass;
  always_comb begin
    m_a = '0; m_b = '0; m_fv = '0; m_err = '0;
    m_busy = 1'b0; m_done = 1'b0; m_pass = 1'b0;
    case (sel)
      1: begin
        m_a = 4'(a1); m_b = 4'(b1); m_fv = 4'(fv1); m_err = 5'(err1);
        m_busy = busy1; m_done = done1; m_pass = pass1;
      end
      2: begin
        m_a = 4'(a2); m_b = 4'(b2); m_fv = 4'(fv2); m_err = 5'(err2);
        m_busy = busy2; m_done = done2; m_pass = pass2;
      end
      3: begin
        m_a = 4'(a3); m_b = 4'(b3); m_fv = fv3; m_err = err3;
        m_busy = busy3; m_done = done3; m_pass = pass3;
      end
      default: ;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_start(input int inst, input logic v);
    case (inst)
      1: st1 = v;
      2: st2 = v;
      default: st3 = v;
    endcase
  endtask

  typedef struct {
    int inst;
    int fm;
    int lat;
    int err;
    int fv;
    int pass;
    int repulse;
  } case_t;

  typedef struct {
    int a;
    int b;
  } ab_t;

  case_t tbl[5];
  ab_t   sb[$];

  task automatic run_case(input int idx);
    case_t cs;
    int    w, sc, last;
    ab_t   e;
    cs  = tbl[idx];
    sel = cs.inst;
    w   = (cs.inst == 3) ? 2 : 1;
    sc  = (cs.inst == 1) ? 2 : 1;
    if (cs.inst == 1) fm1 = cs.fm;
    if (cs.inst == 2) fm2 = cs.fm;
    sb.delete();
    for (int t = 0; t < cs.lat; t++) begin
      int v;
      v   = t / (sc + 1);
      e.a = v >> w;
      e.b = v & ((1 << w) - 1);
      sb.push_back(e);
    end
    @(negedge clk);
    drive_start(cs.inst, 1'b1);
    @(negedge clk);
    drive_start(cs.inst, 1'b0);
    #1;
    for (int t = 0; t < cs.lat; t++) begin
      e = sb.pop_front();
      chk($sformatf("case%0d a t=%0d", idx, t), 32'(m_a), e.a);
      chk($sformatf("case%0d b t=%0d", idx, t), 32'(m_b), e.b);
      chk($sformatf("case%0d busy t=%0d", idx, t), 32'(m_busy), 1);
      chk($sformatf("case%0d done t=%0d", idx, t), 32'(m_done), 0);
      if (t == 0) begin
        chk($sformatf("case%0d err cleared", idx), 32'(m_err), 0);
        chk($sformatf("case%0d fail_vec cleared", idx), 32'(m_fv), 0);
        chk($sformatf("case%0d pass cleared", idx), 32'(m_pass), 0);
      end
      drive_start(cs.inst, (cs.repulse != 0) && (t == 3 || t == 7));
      @(negedge clk);
      #1;
    end
    drive_start(cs.inst, 1'b0);
    last = (1 << w) - 1;
    chk($sformatf("case%0d done at latency", idx), 32'(m_done), 1);
    chk($sformatf("case%0d busy at end", idx), 32'(m_busy), 0);
    chk($sformatf("case%0d pass", idx), 32'(m_pass), cs.pass);
    chk($sformatf("case%0d err_count", idx), 32'(m_err), cs.err);
    chk($sformatf("case%0d fail_vec", idx), 32'(m_fv), cs.fv);
    chk($sformatf("case%0d a last", idx), 32'(m_a), last);
    chk($sformatf("case%0d b last", idx), 32'(m_b), last);
    chk($sformatf("case%0d scoreboard drained", idx), sb.size(), 0);
    @(negedge clk);
    #1;
    chk($sformatf("case%0d done holds", idx), 32'(m_done), 1);
    chk($sformatf("case%0d err holds", idx), 32'(m_err), cs.err);
  endtask

  initial begin
    rst = 1'b1;
    st1 = 1'b0; st2 = 1'b0; st3 = 1'b0;
    fm1 = 0; fm2 = 0; sel = 1;
    //          inst fm lat err fv pass repulse
    tbl[0] = '{1, 0, 12, 0, 0, 1, 1};
    tbl[1] = '{1, 1, 12, 1, 3, 0, 0};
    tbl[2] = '{2, 2,  8, 4, 0, 0, 0};
    tbl[3] = '{3, 0, 32, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 12, 0, 0, 1, 0};

    repeat (3) @(negedge clk);
    for (int i = 1; i <= 3; i++) begin
      sel = i;
      #1;
      chk($sformatf("reset inst%0d a", i), 32'(m_a), 0);
      chk($sformatf("reset inst%0d b", i), 32'(m_b), 0);
      chk($sformatf("reset inst%0d busy", i), 32'(m_busy), 0);
      chk($sformatf("reset inst%0d done", i), 32'(m_done), 0);
      chk($sformatf("reset inst%0d pass", i), 32'(m_pass), 0);
      chk($sformatf("reset inst%0d err", i), 32'(m_err), 0);
      chk($sformatf("reset inst%0d fail_vec", i), 32'(m_fv), 0);
    end
    rst = 1'b0;

    // Good run with start re-pulsed mid-run, then restart from DONE into a
    // faulty run (carry stuck at 0).
    run_case(0);
    run_case(1);

    // Reset mid-run, with start asserted alongside reset.
    sel = 1;
    fm1 = 0;
    @(negedge clk);
    st1 = 1'b1;
    @(negedge clk);
    st1 = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("pre-reset busy", 32'(m_busy), 1);
    rst = 1'b1;
    st1 = 1'b1;
    @(negedge clk);
    #1;
    chk("rst busy", 32'(m_busy), 0);
    chk("rst done", 32'(m_done), 0);
    chk("rst a", 32'(m_a), 0);
    chk("rst b", 32'(m_b), 0);
    chk("rst err", 32'(m_err), 0);
    rst = 1'b0;
    st1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle after rst busy", 32'(m_busy), 0);
    chk("idle after rst a", 32'(m_a), 0);
    run_case(4);

    // Sum inverted with S=1, then the 2-bit adder.
    run_case(2);
    run_case(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
